// File: rtl/auction_seq_ctrl.sv
// ---------------------------------------------------------------------------
// auction_seq_ctrl
// Sequential sealed-bid auction controller. Bids arrive one per accepted
// valid/ready beat in bidder order 0..2**N-1. A single W-bit comparator
// tracks the running maximum (and, optionally, the runner-up). The winner
// and price are then held until the consumer acknowledges.
//
// Optional feature (compile-time macro):
//   AUCTION_SECOND_PRICE_EN  - Vickrey mode: win_price is the second-highest
//                              bid (ties included). Undefined: win_price is
//                              the highest bid. The port list is the same.
//
// Ports:
//   clk          in   clock, rising edge
//   rst_n        in   asynchronous active-low reset
//   start        in   begin a round (honoured only when idle)
//   bid_valid    in   bid_data is valid
//   bid_ready    out  controller accepts a bid this cycle
//   bid_data     in   [W-1:0] unsigned bid of the current bidder
//   busy         out  high from accepted start until result handshake
//   result_valid out  winner / win_price are valid
//   result_ack   in   consumer takes the result
//   winner       out  [N-1:0] index of the winning bidder
//   win_price    out  [W-1:0] price to be paid
// ---------------------------------------------------------------------------
module auction_seq_ctrl #(
    parameter int unsigned N = 2,
    parameter int unsigned W = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic         bid_valid,
    output logic         bid_ready,
    input  logic [W-1:0] bid_data,
    output logic         busy,
    output logic         result_valid,
    input  logic         result_ack,
    output logic [N-1:0] winner,
    output logic [W-1:0] win_price
);

    localparam int unsigned CNT_W = N + 1;
    localparam int unsigned NBID  = 1 << N;

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_COLLECT = 2'd1;
    localparam logic [1:0] S_RESULT  = 2'd2;

    logic [1:0]       state_q,  state_d;
    logic [CNT_W-1:0] count_q,  count_d;
    logic [W-1:0]     max_q,    max_d;
    logic [N-1:0]     winner_q, winner_d;
    logic             busy_q,   busy_d;
    logic             rv_q,     rv_d;
    logic             ready_q,  ready_d;
`ifdef AUCTION_SECOND_PRICE_EN
    logic [W-1:0]     second_q, second_d;
`endif

    logic accept;
    logic last_beat;

    assign accept    = bid_valid & ready_q;
    assign last_beat = (count_q == CNT_W'(NBID - 1));

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            count_q  <= '0;
            max_q    <= '0;
            winner_q <= '0;
            busy_q   <= 1'b0;
            rv_q     <= 1'b0;
            ready_q  <= 1'b0;
`ifdef AUCTION_SECOND_PRICE_EN
            second_q <= '0;
`endif
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            max_q    <= max_d;
            winner_q <= winner_d;
            busy_q   <= busy_d;
            rv_q     <= rv_d;
            ready_q  <= ready_d;
`ifdef AUCTION_SECOND_PRICE_EN
            second_q <= second_d;
`endif
        end
    end

    // Next-state, comparator and registered-output logic
    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        max_d    = max_q;
        winner_d = winner_q;
        busy_d   = busy_q;
        rv_d     = rv_q;
        ready_d  = ready_q;
`ifdef AUCTION_SECOND_PRICE_EN
        second_d = second_q;
`endif

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_COLLECT;
                    busy_d  = 1'b1;
                    ready_d = 1'b1;
                    count_d = '0;
                end
            end

            S_COLLECT: begin
                if (accept) begin
                    count_d = count_q + CNT_W'(1);
                    if (count_q == '0) begin
                        // First beat seeds the round; stale values are dropped
                        max_d    = bid_data;
                        winner_d = '0;
`ifdef AUCTION_SECOND_PRICE_EN
                        second_d = '0;
`endif
                    end else if (bid_data > max_q) begin
                        max_d    = bid_data;
                        winner_d = N'(count_q);
`ifdef AUCTION_SECOND_PRICE_EN
                        second_d = max_q;
`endif
                    end
`ifdef AUCTION_SECOND_PRICE_EN
                    // Tie with the max loses but still sets the runner-up
                    else if ((bid_data > second_q) || (bid_data == max_q)) begin
                        second_d = bid_data;
                    end
`endif
                    if (last_beat) begin
                        state_d = S_RESULT;
                        ready_d = 1'b0;
                        rv_d    = 1'b1;
                    end
                end
            end

            S_RESULT: begin
                if (result_ack) begin
                    state_d = S_IDLE;
                    rv_d    = 1'b0;
                    busy_d  = 1'b0;
                end
            end

            default: begin
                state_d = S_IDLE;
                ready_d = 1'b0;
                rv_d    = 1'b0;
                busy_d  = 1'b0;
            end
        endcase
    end

    assign bid_ready    = ready_q;
    assign busy         = busy_q;
    assign result_valid = rv_q;
    assign winner       = winner_q;
`ifdef AUCTION_SECOND_PRICE_EN
    assign win_price    = second_q;
`else
    assign win_price    = max_q;
`endif

endmodule

// File: tb/tb_auction_seq_ctrl.sv
// Self-checking bench for auction_seq_ctrl (N=2, W=4).
module tb_auction_seq_ctrl;

    localparam int unsigned N = 2;
    localparam int unsigned W = 4;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic         bid_valid;
    logic         bid_ready;
    logic [W-1:0] bid_data;
    logic         busy;
    logic         result_valid;
    logic         result_ack;
    logic [N-1:0] winner;
    logic [W-1:0] win_price;

    int errors = 0;
    int checks = 0;

    auction_seq_ctrl #(.N(N), .W(W)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .bid_valid    (bid_valid),
        .bid_ready    (bid_ready),
        .bid_data     (bid_data),
        .busy         (busy),
        .result_valid (result_valid),
        .result_ack   (result_ack),
        .winner       (winner),
        .win_price    (win_price)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One record per directed round: bids packed b0 at [3:0], bubble counts
    // before each beat packed 2 bits each, extra RESULT hold cycles.
    typedef struct {
        string       name;
        logic [15:0] bids;
        logic [7:0]  gaps;
        int          hold;
        bit          poke;
        logic [1:0]  exp_w;
        logic [3:0]  exp_fp;
        logic [3:0]  exp_sp;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: first index holding the maximum; price is the top (first
    // price) or the second element of the bids sorted descending (Vickrey).
    task automatic model(input logic [15:0] bids, output logic [1:0] w, output logic [3:0] p);
        int v[4];
        int best;
        int t;
        for (int i = 0; i < 4; i++) v[i] = int'(bids[4*i +: 4]);
        best = 0;
        for (int i = 1; i < 4; i++) if (v[i] > v[best]) best = i;
        w = 2'(best);
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 3 - i; j++)
                if (v[j] < v[j+1]) begin t = v[j]; v[j] = v[j+1]; v[j+1] = t; end
`ifdef AUCTION_SECOND_PRICE_EN
        p = 4'(v[1]);
`else
        p = 4'(v[0]);
`endif
    endtask

    task automatic run_round(input string nm, input logic [15:0] bids, input logic [7:0] gaps,
                             input int hold, input bit poke,
                             input logic [1:0] ew, input logic [3:0] ep);
        chk({nm, " idle_busy"},  32'(busy), 32'd0);
        chk({nm, " idle_ready"}, 32'(bid_ready), 32'd0);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk({nm, " busy_on"},  32'(busy), 32'd1);
        chk({nm, " ready_on"}, 32'(bid_ready), 32'd1);
        for (int i = 0; i < 4; i++) begin
            for (int g = 0; g < int'(gaps[2*i +: 2]); g++) begin
                bid_valid = 1'b0;
                bid_data  = 4'($urandom);
                start     = poke;
                tick();
                start     = 1'b0;
                chk({nm, " bubble_rv"},    32'(result_valid), 32'd0);
                chk({nm, " bubble_ready"}, 32'(bid_ready), 32'd1);
            end
            bid_valid = 1'b1;
            bid_data  = bids[4*i +: 4];
            start     = poke && (i == 1);
            tick();
            bid_valid = 1'b0;
            start     = 1'b0;
            if (i < 3) begin
                chk({nm, " beat_rv"},    32'(result_valid), 32'd0);
                chk({nm, " beat_ready"}, 32'(bid_ready), 32'd1);
            end else begin
                chk({nm, " res_rv"},     32'(result_valid), 32'd1);
                chk({nm, " res_ready"},  32'(bid_ready), 32'd0);
                chk({nm, " winner"},     32'(winner), 32'(ew));
                chk({nm, " price"},      32'(win_price), 32'(ep));
                chk({nm, " res_busy"},   32'(busy), 32'd1);
            end
        end
        for (int h = 0; h < hold; h++) begin
            start = poke;
            tick();
            start = 1'b0;
            chk({nm, " hold_rv"},     32'(result_valid), 32'd1);
            chk({nm, " hold_winner"}, 32'(winner), 32'(ew));
            chk({nm, " hold_price"},  32'(win_price), 32'(ep));
        end
        result_ack = 1'b1;
        start      = poke;
        tick();
        result_ack = 1'b0;
        start      = 1'b0;
        chk({nm, " ack_rv"},     32'(result_valid), 32'd0);
        chk({nm, " ack_busy"},   32'(busy), 32'd0);
        chk({nm, " keep_win"},   32'(winner), 32'(ew));
        chk({nm, " keep_price"}, 32'(win_price), 32'(ep));
        tick();
        chk({nm, " idle_stay"},  32'(busy), 32'd0);
        chk({nm, " idle_rv"},    32'(result_valid), 32'd0);
    endtask

    vec_t vecs[4];

    initial begin
        logic [15:0] rb;
        logic [7:0]  rg;
        logic [1:0]  mw;
        logic [3:0]  mp;
        logic [3:0]  ep;

        vecs[0] = '{"basic",   {4'd7, 4'd5, 4'd9, 4'd3},   8'h00, 2, 1'b0, 2'd1, 4'd9,  4'd7};
        vecs[1] = '{"tie",     {4'd6, 4'd6, 4'd2, 4'd6},   8'h00, 0, 1'b0, 2'd0, 4'd6,  4'd6};
        vecs[2] = '{"bubble",  {4'd2, 4'd15, 4'd4, 4'd1},  8'b01_00_10_00, 4, 1'b1, 2'd2, 4'd15, 4'd4};
        vecs[3] = '{"zeros",   {4'd0, 4'd0, 4'd0, 4'd0},   8'h00, 1, 1'b1, 2'd0, 4'd0,  4'd0};

        rst_n      = 1'b0;
        start      = 1'b0;
        bid_valid  = 1'b0;
        bid_data   = '0;
        result_ack = 1'b0;
        tick();
        tick();
        chk("rst_ready",  32'(bid_ready), 32'd0);
        chk("rst_busy",   32'(busy), 32'd0);
        chk("rst_rv",     32'(result_valid), 32'd0);
        chk("rst_winner", 32'(winner), 32'd0);
        chk("rst_price",  32'(win_price), 32'd0);
        rst_n = 1'b1;
        tick();

        for (int k = 0; k < 4; k++) begin
`ifdef AUCTION_SECOND_PRICE_EN
            ep = vecs[k].exp_sp;
`else
            ep = vecs[k].exp_fp;
`endif
            run_round(vecs[k].name, vecs[k].bids, vecs[k].gaps, vecs[k].hold,
                      vecs[k].poke, vecs[k].exp_w, ep);
        end

        // Abort after two accepted beats: outputs clear without a clock edge
        start = 1'b1;
        tick();
        start = 1'b0;
        bid_valid = 1'b1;
        bid_data  = 4'd12;
        tick();
        bid_data  = 4'd13;
        tick();
        bid_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("abort_ready",  32'(bid_ready), 32'd0);
        chk("abort_busy",   32'(busy), 32'd0);
        chk("abort_rv",     32'(result_valid), 32'd0);
        chk("abort_winner", 32'(winner), 32'd0);
        chk("abort_price",  32'(win_price), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        tick();
`ifdef AUCTION_SECOND_PRICE_EN
        run_round("post_rst", {4'd1, 4'd0, 4'd0, 4'd0}, 8'h00, 0, 1'b0, 2'd3, 4'd0);
`else
        run_round("post_rst", {4'd1, 4'd0, 4'd0, 4'd0}, 8'h00, 0, 1'b0, 2'd3, 4'd1);
`endif

        // Back-to-back random rounds against the reference model
        for (int r = 0; r < 10; r++) begin
            rb = 16'($urandom);
            rg = 8'($urandom) & 8'h55;
            model(rb, mw, mp);
            run_round("rand", rb, rg, int'($urandom_range(0, 3)), 1'($urandom), mw, mp);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/auction_seq_ctrl.md
Name: auction_seq_ctrl

Overview:
- Sequential, resource-shared sealed-bid auction controller.
- Accepts 2**N bids serially, one per accepted beat, in bidder-index order 0..2**N-1, over a valid/ready handshake.
- Tracks the running highest bid and its bidder index using one W-bit comparator, then presents the winner index and price until the consumer acknowledges.
- Sits between a bid source (e.g. a garbled-circuit input stream or bus) and the downstream result consumer. It is the area-lean, time-multiplexed alternative to a fully parallel comparator tree.

Parameters:
- N, 2, log2 of bidder count (2**N bidders, N >= 1)
- W, 2, bid width in bits (unsigned)

Ports:
- clk  input  1  clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- start  input  1  pulse; begins a new auction round when idle
- bid_valid  input  1  bid_data valid
- bid_ready  output  1  controller accepts a bid this cycle
- bid_data  input  W  unsigned bid of the current bidder
- busy  output  1  high from accepted start until result_ack handshake
- result_valid  output  1  winner/win_price valid
- result_ack  input  1  consumer accepts the result
- winner  output  N  index of the winning bidder
- win_price  output  W  price to be paid (see Optional Feature)

Behaviour:
- Reset (async, rst_n=0):
  - FSM goes to IDLE.
  - bid_ready=0, busy=0, result_valid=0, winner=0, win_price=0.
  - Internal max, second, count and index are cleared to 0.
- FSM states: IDLE, COLLECT, RESULT.
- IDLE:
  - bid_ready=0.
  - start=1 -> COLLECT next cycle. busy=1 and count=0 from that edge.
- COLLECT:
  - bid_ready=1 every cycle.
  - A beat is accepted when bid_valid & bid_ready.
  - Beat with count==0: max<=bid_data, winner<=0.
  - Later beats: if bid_data > max (strictly), max<=bid_data and winner<=count.
  - Ties keep the earlier (lower-index) bidder.
  - count increments per accepted beat. count is N+1 bits wide, so there is no wrap inside a round.
  - No accepted beat: state and count hold. Bubbles are allowed indefinitely.
  - Accepting beat 2**N-1 -> RESULT next cycle. bid_ready drops in the same cycle RESULT is entered.
- RESULT:
  - result_valid=1; winner and win_price stable.
  - result_ack=1 -> IDLE next cycle, with result_valid=0 and busy=0.
  - winner and win_price keep their last values in IDLE until the next round's first accepted beat.
- start is ignored outside IDLE (no restart mid-round).
- start and result_ack asserted in the same RESULT cycle: ack is honoured, start is ignored. A new round needs start while in IDLE.
- Latency: result_valid is asserted on the cycle after the final accepted beat. Minimum round is 1 (start) + 2**N beats + 1 result cycle.
- Reset asserted mid-round aborts the round immediately. No partial result is ever presented.
- All comparisons are unsigned W-bit. No arithmetic overflow is possible.
- win_price (first-price mode) = max.

Optional Feature:
- Macro: AUCTION_SECOND_PRICE_EN
- Defined (Vickrey auction):
  - The controller also tracks the second-highest bid.
  - When a new strict max arrives: second<=old max, max<=bid.
  - Otherwise, if bid > second, or bid == max with the tie lost: second<=bid.
  - win_price = second-highest bid value, including ties. Example: two equal highest bids -> price equals that value.
  - For N such that 2**N >= 2 the second value is always defined.
- Undefined:
  - No second register is present.
  - win_price = highest bid (first-price).
  - Port list is unchanged.

Test Plan:
- N=2,W=4; start, bids 3,9,5,7 back-to-back -> result_valid on the cycle after the 4th beat, winner=1, win_price=9 (7 with AUCTION_SECOND_PRICE_EN); hold until ack, then busy=0.
- Tie: bids 6,2,6,6 -> winner=0; win_price=6 in both modes.
- Bubbles and back-pressure: bid_valid toggled 1,0,0,1,1,0,1 with bids 1,4,15,2 -> winner=2, win_price=15 (4 second-price); count never advances on bubbles; result_valid held 5 cycles until result_ack.
- start pulsed during COLLECT and during RESULT (with and without result_ack) -> ignored; only an IDLE start launches a round; no result_valid glitch.
- rst_n asserted after 2 accepted beats -> all outputs 0 immediately (async); new round with bids 0,0,0,1 -> winner=3, win_price=1 (0 second-price).
- All-zero bids 0,0,0,0 -> winner=0, win_price=0; repeat back-to-back rounds 10x with random bids vs a reference model.
